node_sequencer: RTL and testbench

Control-side initiator for the neural-network node datapath. It accepts one input frame per handshake and drives the node's accumulator controls: `reset_acc`, `start` (active-low accumulate enable) and `cnt_val`. It walks `cnt_val` across all coefficient/data pairs, waits for the activation output to settle, then captures `node_out` into a held result with a valid/ack handshake. It sits between the layer scheduler (upstream) and one node instance (downstream).

---
 rtl/node_pkg.sv | 19 +
 rtl/node_sequencer_if.sv | 33 +++
 rtl/node_cnt.sv | 30 +++
 rtl/node_sequencer.sv | 107 ++++++++++
 tb/tb_node_sequencer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/node_pkg.sv
// Shared types and default sizes for the node sequencer slice.
// Used by node_sequencer and its interface; NODE_SEQ_ABORT_EN is honoured by the top.
package node_pkg;

    typedef logic [15:0] double;

    localparam int NODE_INPUTS = 64;
    localparam int NODE_CNT_W  = 7;
    localparam int NODE_OUT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        SETTLE,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/node_sequencer_if.sv
// Frame/result handshake and node control bundle.
// slave = sequencer side, master = scheduler/node side.
interface node_sequencer_if
    import node_pkg::*;
#(
    parameter int CNT_W = NODE_CNT_W,
    parameter int OUT_W = NODE_OUT_W
) ();

    logic             frame_valid;
    logic             frame_ready;
    logic             reset_acc;
    logic             start;
    logic [CNT_W-1:0] cnt_val;
    logic [OUT_W-1:0] node_out;
    logic [OUT_W-1:0] result;
    logic             result_valid;
    logic             result_ack;
    logic             busy;

    modport master (
        output frame_valid, node_out, result_ack,
        input  frame_ready, reset_acc, start, cnt_val,
        input  result, result_valid, busy
    );

    modport slave (
        input  frame_valid, node_out, result_ack,
        output frame_ready, reset_acc, start, cnt_val,
        output result, result_valid, busy
    );

endinterface

// File: rtl/node_cnt.sv
// Up-counter with clear, enable and a rollover flag raised at i_roll.
// Wraps to zero on the enabled cycle where the flag is set.
module node_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_roll,
    output logic [W-1:0] o_cnt,
    output logic         o_roll
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_roll ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_roll = (r_cnt == i_roll);

endmodule

// File: rtl/node_sequencer.sv
// Node accumulator sequencer: CLEAR, ACCUM over all pairs, SETTLE, HOLD result.
// Define NODE_SEQ_ABORT_EN to add the abort input.
module node_sequencer
    import node_pkg::*;
#(
    parameter int NUM_INPUTS    = NODE_INPUTS,
    parameter int CNT_W         = NODE_CNT_W,
    parameter int OUT_W         = NODE_OUT_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic n_rst,
`ifdef NODE_SEQ_ABORT_EN
    input  logic abort,
`endif
    node_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);
    localparam logic [3:0]       LAST_SET = 4'(SETTLE_CYCLES - 1);

    seq_state_t       r_state;
    logic [OUT_W-1:0] r_result;
    logic             r_valid;
    logic             r_abort;

    logic [CNT_W-1:0] w_idx;
    logic             w_idx_last;
    logic [3:0]       w_set_cnt;
    logic             w_set_last;
    logic             w_kill;
    logic             w_ack;
    logic             w_unused_set;

    // abort kills an in-flight frame; in HOLD it acts as an ack
`ifdef NODE_SEQ_ABORT_EN
    assign w_kill = abort && (r_state == CLEAR ||
                              r_state == ACCUM ||
                              r_state == SETTLE);
    assign w_ack  = bus.result_ack | abort;
`else
    assign w_kill = 1'b0;
    assign w_ack  = bus.result_ack;
`endif

    node_cnt #(.W(CNT_W)) u_idx (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_clr  (w_kill || r_state != ACCUM),
        .i_en   (r_state == ACCUM),
        .i_roll (LAST_IDX),
        .o_cnt  (w_idx),
        .o_roll (w_idx_last)
    );

    node_cnt #(.W(4)) u_settle (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_clr  (w_kill || r_state != SETTLE),
        .i_en   (r_state == SETTLE),
        .i_roll (LAST_SET),
        .o_cnt  (w_set_cnt),
        .o_roll (w_set_last)
    );

    assign w_unused_set = ^w_set_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_abort  <= 1'b0;
        end else if (w_kill) begin
            r_state <= CLEAR;
            r_abort <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: if (bus.frame_valid) r_state <= CLEAR;
                CLEAR: begin
                    r_abort <= 1'b0;
                    r_state <= r_abort ? IDLE : ACCUM;
                end
                ACCUM: if (w_idx_last) r_state <= SETTLE;
                SETTLE: if (w_set_last) begin
                    r_result <= bus.node_out;
                    r_valid  <= 1'b1;
                    r_state  <= HOLD;
                end
                HOLD: if (w_ack) begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.frame_ready  = (r_state == IDLE);
    assign bus.busy         = (r_state != IDLE);
    assign bus.reset_acc    = (r_state == CLEAR);
    assign bus.start        = (r_state != ACCUM);
    assign bus.cnt_val      = w_idx;
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;

endmodule

// File: tb/tb_node_sequencer.sv
// Randomised self-checking bench for node_sequencer.
// Build with NODE_SEQ_ABORT_EN to also exercise abort.
module tb_node_sequencer;
    import node_pkg::*;

    localparam int N = 64;
    localparam int S = 1;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    node_sequencer_if #(.CNT_W(7), .OUT_W(3)) bus ();

`ifdef NODE_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    node_sequencer #(
        .NUM_INPUTS    (N),
        .CNT_W         (7),
        .OUT_W         (3),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
`ifdef NODE_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [2:0] exp_res;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string ctx);
        chk({ctx, "_ready"}, 32'(bus.frame_ready), 1);
        chk({ctx, "_busy"}, 32'(bus.busy), 0);
        chk({ctx, "_start"}, 32'(bus.start), 1);
        chk({ctx, "_rstacc"}, 32'(bus.reset_acc), 0);
        chk({ctx, "_cnt"}, 32'(bus.cnt_val), 0);
        chk({ctx, "_rv"}, 32'(bus.result_valid), 0);
        chk({ctx, "_res"}, 32'(bus.result), 32'(exp_res));
    endtask

    // One frame: timeline is derived from cycles since the handshake edge
    task automatic run_frame(input logic [2:0] val, input int hold,
                             input bit simul);
        chk("pre_ready", 32'(bus.frame_ready), 1);
        chk("pre_rstacc", 32'(bus.reset_acc), 0);
        bus.frame_valid = 1'b1;
        tick;
        bus.frame_valid = 1'b0;
        chk("clr_rstacc", 32'(bus.reset_acc), 1);
        chk("clr_start", 32'(bus.start), 1);
        chk("clr_cnt", 32'(bus.cnt_val), 0);
        chk("clr_busy", 32'(bus.busy), 1);
        chk("clr_ready", 32'(bus.frame_ready), 0);
        tick;
        for (int i = 0; i < N; i++) begin
            chk("acc_start", 32'(bus.start), 0);
            chk("acc_cnt", 32'(bus.cnt_val), i);
            chk("acc_rstacc", 32'(bus.reset_acc), 0);
            bus.node_out    = (i >= N - 4) ? val : 3'($urandom);
            bus.frame_valid = 1'($urandom_range(0, 1));
            bus.result_ack  = 1'($urandom_range(0, 1));
            tick;
        end
        bus.frame_valid = 1'b0;
        bus.result_ack  = 1'b0;
        for (int s = 0; s < S; s++) begin
            chk("set_start", 32'(bus.start), 1);
            chk("set_rv", 32'(bus.result_valid), 0);
            chk("set_cnt", 32'(bus.cnt_val), 0);
            tick;
        end
        exp_res = val;
        for (int h = 0; h <= hold; h++) begin
            chk("hold_rv", 32'(bus.result_valid), 1);
            chk("hold_res", 32'(bus.result), 32'(exp_res));
            chk("hold_cnt", 32'(bus.cnt_val), 0);
            chk("hold_ready", 32'(bus.frame_ready), 0);
            bus.frame_valid = 1'($urandom_range(0, 1));
            bus.node_out    = 3'($urandom);
            if (h < hold) tick;
        end
        bus.result_ack  = 1'b1;
        bus.frame_valid = simul;
        tick;
        bus.result_ack = 1'b0;
        chk("ack_ready", 32'(bus.frame_ready), 1);
        chk("ack_busy", 32'(bus.busy), 0);
        chk("ack_rv", 32'(bus.result_valid), 0);
        chk("ack_res", 32'(bus.result), 32'(exp_res));
        chk("ack_rstacc", 32'(bus.reset_acc), 0);
    endtask

    initial begin
        bus.frame_valid = 1'b0;
        bus.result_ack  = 1'b0;
        bus.node_out    = 3'd0;
        exp_res         = 3'd0;
        tick;
        tick;
        idle_chk("rst_held");
        n_rst = 1'b1;
        tick;
        idle_chk("rst_rel");

        run_frame(3'b101, 20, 1'b0);
        run_frame(3'b110, 3, 1'b1);
        run_frame(3'b011, 0, 1'b0);

        // asynchronous reset mid-accumulation
        bus.frame_valid = 1'b1;
        tick;
        bus.frame_valid = 1'b0;
        tick;
        repeat (30) tick;
        chk("mid_cnt", 32'(bus.cnt_val), 30);
        n_rst = 1'b0;
        #1;
        exp_res = 3'd0;
        idle_chk("async_rst");
        tick;
        n_rst = 1'b1;
        tick;
        idle_chk("post_rst");
        run_frame(3'($urandom), 2, 1'b0);

        for (int k = 0; k < 6; k++)
            run_frame(3'($urandom), $urandom_range(0, 8),
                      1'($urandom_range(0, 1)));
        bus.frame_valid = 1'b0;
        tick;

`ifdef NODE_SEQ_ABORT_EN
        abort = 1'b1;
        tick;
        abort = 1'b0;
        idle_chk("abort_idle");
        bus.frame_valid = 1'b1;
        tick;
        bus.frame_valid = 1'b0;
        tick;
        repeat (10) tick;
        chk("abort_cnt10", 32'(bus.cnt_val), 10);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_rstacc", 32'(bus.reset_acc), 1);
        chk("abort_cnt", 32'(bus.cnt_val), 0);
        chk("abort_start", 32'(bus.start), 1);
        chk("abort_rv", 32'(bus.result_valid), 0);
        tick;
        for (int j = 0; j < 4; j++) begin
            idle_chk("abort_after");
            tick;
        end
        run_frame(3'b100, 1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
